// File: rtl/rf_hazard_sched_if.sv
// Decode-stage hazard scheduler bus: decode request, control inputs,
// scheduler decisions, retire report and the stall counter.
interface rf_hazard_sched_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [2:0]       id_rs_sel;
  logic             id_rs_used;
  logic [2:0]       id_rt_sel;
  logic             id_rt_used;
  logic             id_wr_en;
  logic [2:0]       id_wr_sel;
  logic             flush;
  logic             mem_busy;
  logic             id_issue;
  logic             stall;
  logic             retire_valid;
  logic [2:0]       retire_sel;
  logic [CNT_W-1:0] stall_cnt;

  // Decode side: presents the instruction and pipe controls
  modport master (
    output id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
           id_wr_en, id_wr_sel, flush, mem_busy,
    input  id_issue, stall, retire_valid, retire_sel, stall_cnt
  );

  // Scheduler side
  modport slave (
    input  id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
           id_wr_en, id_wr_sel, flush, mem_busy,
    output id_issue, stall, retire_valid, retire_sel, stall_cnt
  );
endinterface

// File: rtl/rf_hazard_sched.sv
// Register-file hazard scheduler for the decode stage of the 16-bit core.
// A shift-register scoreboard follows each in-flight destination register
// from issue to write-back; decode stalls on RAW conflicts, freezes while
// data memory is busy and inserts a bubble on flush. Stalled cycles are
// counted (saturating) for performance debug.
// CNT_W must match the CNT_W of the connected interface.
module rf_hazard_sched #(
  parameter int NUM_STAGES = 3,
  parameter int RF_BYPASS  = 1,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             rst,
  rf_hazard_sched_if.slave bus
);

  // Entries checked for RAW hazards; with bypass the oldest (writing) one is skipped.
  localparam int unsigned MATCH_N = NUM_STAGES - RF_BYPASS;

  logic [NUM_STAGES-1:0] v_q, v_d;
  logic [2:0]            sel_q [NUM_STAGES];
  logic [2:0]            sel_d [NUM_STAGES];
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic rs_match, rt_match, hazard;
  logic stall_raw, issue_raw;
  logic stall_w, issue_w;

  // Hazard detection and the issue/stall decision
  always_comb begin
    rs_match = 1'b0;
    rt_match = 1'b0;
    for (int unsigned k = 0; k < MATCH_N; k++) begin
      if (v_q[k] && (sel_q[k] == bus.id_rs_sel)) rs_match = 1'b1;
      if (v_q[k] && (sel_q[k] == bus.id_rt_sel)) rt_match = 1'b1;
    end
    hazard    = bus.id_valid & ((bus.id_rs_used & rs_match) |
                                (bus.id_rt_used & rt_match));
    stall_raw = bus.mem_busy | (hazard & ~bus.flush);
    issue_raw = bus.id_valid & ~bus.mem_busy & ~hazard & ~bus.flush;
    // Reset overrides: nothing issues and fetch is held
    stall_w   = ~rst | stall_raw;
    issue_w   = rst & issue_raw;
  end

  // Scoreboard next state: hold on mem_busy, else shift and load entry 0
  always_comb begin
    v_d   = v_q;
    sel_d = sel_q;
    if (!bus.mem_busy) begin
      for (int unsigned k = NUM_STAGES - 1; k > 0; k--) begin
        v_d[k]   = v_q[k-1];
        sel_d[k] = sel_q[k-1];
      end
      v_d[0]   = issue_w & bus.id_wr_en;
      sel_d[0] = (issue_w & bus.id_wr_en) ? bus.id_wr_sel : 3'b000;
    end
  end

  // Saturating stall counter next state
  always_comb begin
    cnt_d = cnt_q;
    if (stall_w && bus.id_valid && rst && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q   <= '0;
      sel_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.id_issue     = issue_w;
  assign bus.stall        = stall_w;
  assign bus.retire_valid = v_q[NUM_STAGES-1];
  assign bus.retire_sel   = sel_q[NUM_STAGES-1];
  assign bus.stall_cnt    = cnt_q;

endmodule

// File: tb/tb_rf_hazard_sched.sv
// Directed bench for rf_hazard_sched: one instance without bypass (16-bit
// counter) and one with bypass and a 4-bit counter for saturation.
module tb_rf_hazard_sched;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  logic       id_valid = 1'b0;
  logic [2:0] id_rs_sel = '0;
  logic       id_rs_used = 1'b0;
  logic [2:0] id_rt_sel = '0;
  logic       id_rt_used = 1'b0;
  logic       id_wr_en = 1'b0;
  logic [2:0] id_wr_sel = '0;
  logic       flush = 1'b0;
  logic       mem_busy = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_hazard_sched_if #(.CNT_W(16)) if0 ();
  rf_hazard_sched_if #(.CNT_W(4))  if1 ();

  assign if0.id_valid = id_valid;   assign if1.id_valid = id_valid;
  assign if0.id_rs_sel = id_rs_sel; assign if1.id_rs_sel = id_rs_sel;
  assign if0.id_rs_used = id_rs_used; assign if1.id_rs_used = id_rs_used;
  assign if0.id_rt_sel = id_rt_sel; assign if1.id_rt_sel = id_rt_sel;
  assign if0.id_rt_used = id_rt_used; assign if1.id_rt_used = id_rt_used;
  assign if0.id_wr_en = id_wr_en;   assign if1.id_wr_en = id_wr_en;
  assign if0.id_wr_sel = id_wr_sel; assign if1.id_wr_sel = id_wr_sel;
  assign if0.flush = flush;         assign if1.flush = flush;
  assign if0.mem_busy = mem_busy;   assign if1.mem_busy = mem_busy;

  rf_hazard_sched #(.NUM_STAGES(3), .RF_BYPASS(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst0), .bus(if0)
  );

  rf_hazard_sched #(.NUM_STAGES(3), .RF_BYPASS(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1), .bus(if1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic v, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic we,
                       input logic [2:0] ws, input logic fl, input logic mb);
    id_valid = v;  id_rs_sel = rs; id_rs_used = rsu;
    id_rt_sel = rt; id_rt_used = rtu; id_wr_en = we;
    id_wr_sel = ws; flush = fl; mem_busy = mb;
  endtask

  task automatic idle();
    setin(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // ---------------- reset state (dut0) ----------------
    cyc(); cyc();
    setin(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    #1;
    chk("rst_issue", if0.id_issue, 0);
    chk("rst_stall", if0.stall, 1);
    chk("rst_rv", if0.retire_valid, 0);
    chk("rst_rsel", if0.retire_sel, 0);
    chk("rst_cnt", if0.stall_cnt, 0);
    cyc(); rst0 = 1'b1; idle(); #1;
    chk("idle_stall", if0.stall, 0);

    // ---------------- RAW on r1, no bypass ----------------
    cyc(); setin(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0); #1;   // t
    chk("raw_prod_issue", if0.id_issue, 1);
    chk("raw_prod_stall", if0.stall, 0);
    for (int i = 1; i <= 3; i++) begin                                      // t+1..t+3
      cyc(); setin(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0); #1;
      chk("raw_stall", if0.stall, 1);
      chk("raw_noissue", if0.id_issue, 0);
    end
    chk("raw_retire_v", if0.retire_valid, 1);
    chk("raw_retire_sel", if0.retire_sel, 1);
    cyc(); #1;                                                              // t+4
    chk("raw_issue_t4", if0.id_issue, 1);
    chk("raw_stall_t4", if0.stall, 0);
    chk("raw_cnt", if0.stall_cnt, 3);

    // ---------------- unused rt matching in-flight r2 ----------------
    cyc(); setin(1'b1, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); #1; // t+5
    chk("rt_unused_issue", if0.id_issue, 1);
    chk("rt_unused_stall", if0.stall, 0);
    chk("rt_unused_rv", if0.retire_valid, 0);
    cyc(); setin(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0); #1; // t+6
    chk("rt_used_stall", if0.stall, 1);

    // ---------------- mem_busy freeze with {r2, r5, bubble} ----------------
    cyc(); idle(); #1;                                                      // t+7
    cyc(); idle(); #1;                                                      // t+8
    cyc(); setin(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0); #1; // t+9
    chk("busy_prod5", if0.id_issue, 1);
    cyc(); setin(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0); #1; // t+10
    chk("busy_prod2", if0.id_issue, 1);
    cyc(); setin(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1); #1; // t+11
    chk("busy_stall1", if0.stall, 1);
    chk("busy_noissue1", if0.id_issue, 0);
    chk("busy_rv1", if0.retire_valid, 0);
    chk("busy_cnt1", if0.stall_cnt, 4);
    cyc(); setin(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1); #1; // t+12
    chk("busy_flush_stall", if0.stall, 1);
    chk("busy_noissue2", if0.id_issue, 0);
    chk("busy_rv2", if0.retire_valid, 0);
    chk("busy_cnt2", if0.stall_cnt, 5);
    cyc(); idle(); #1;                                                      // t+13
    chk("busy_after_stall", if0.stall, 0);
    chk("busy_after_rv", if0.retire_valid, 0);
    chk("busy_after_cnt", if0.stall_cnt, 6);
    cyc(); idle(); #1;                                                      // t+14
    chk("busy_ret5_v", if0.retire_valid, 1);
    chk("busy_ret5_sel", if0.retire_sel, 5);
    cyc(); idle(); #1;                                                      // t+15
    chk("busy_ret2_v", if0.retire_valid, 1);
    chk("busy_ret2_sel", if0.retire_sel, 2);

    // ---------------- flush over a hazard ----------------
    cyc(); setin(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0); #1; // t+16
    chk("fl_prod3", if0.id_issue, 1);
    cyc(); setin(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0); #1; // t+17
    chk("fl_issue", if0.id_issue, 0);
    chk("fl_stall", if0.stall, 0);
    cyc(); setin(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); #1; // t+18
    chk("fl_fresh_issue", if0.id_issue, 1);
    chk("fl_fresh_stall", if0.stall, 0);
    chk("fl_cnt", if0.stall_cnt, 6);
    cyc(); idle(); #1;                                                      // t+19
    chk("fl_old_retire_v", if0.retire_valid, 1);
    chk("fl_old_retire_sel", if0.retire_sel, 3);

    // ---------------- reset with three valid entries ----------------
    for (int i = 1; i <= 3; i++) begin
      cyc(); setin(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'(i), 1'b0, 1'b0); #1;
      chk("rr_fill_issue", if0.id_issue, 1);
    end
    cyc(); rst0 = 1'b0;
    setin(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0); #1;
    chk("rr_full_rv", if0.retire_valid, 1);
    chk("rr_full_sel", if0.retire_sel, 1);
    chk("rr_forced_stall", if0.stall, 1);
    chk("rr_forced_issue", if0.id_issue, 0);
    cyc(); rst0 = 1'b1; idle(); #1;
    chk("rr_rv", if0.retire_valid, 0);
    chk("rr_sel", if0.retire_sel, 0);
    chk("rr_cnt", if0.stall_cnt, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(); idle(); #1;
      chk("rr_no_retire", if0.retire_valid, 0);
    end

    // ---------------- eight independent instructions ----------------
    for (int i = 0; i < 8; i++) begin
      cyc();
      setin(1'b1, 3'((i + 4) % 8), 1'b1, 3'((i + 1) % 8), 1'b1, 1'b1, 3'(i), 1'b0, 1'b0);
      #1;
      chk("ind_issue", if0.id_issue, 1);
      chk("ind_stall", if0.stall, 0);
      chk("ind_rv", if0.retire_valid, (i >= 3) ? 1 : 0);
      if (i >= 3) chk("ind_rsel", if0.retire_sel, 32'(i - 3));
    end
    cyc(); idle(); #1;
    chk("ind_cnt", if0.stall_cnt, 0);

    // ---------------- bypass instance: RAW and counter saturation ----------------
    cyc(); rst0 = 1'b0; rst1 = 1'b1; idle(); #1;
    chk("byp_rst_cnt", if1.stall_cnt, 0);
    chk("byp_rst_rv", if1.retire_valid, 0);
    cyc(); setin(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0); #1;
    chk("byp_prod_issue", if1.id_issue, 1);
    for (int i = 1; i <= 2; i++) begin
      cyc(); setin(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0); #1;
      chk("byp_stall", if1.stall, 1);
      chk("byp_noissue", if1.id_issue, 0);
    end
    cyc(); #1;
    chk("byp_issue_t3", if1.id_issue, 1);
    chk("byp_stall_t3", if1.stall, 0);
    chk("byp_cnt", if1.stall_cnt, 2);
    for (int j = 1; j <= 20; j++) begin
      cyc(); setin(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); #1;
      if (j == 13) chk("sat_cnt_14", if1.stall_cnt, 14);
      if (j == 14) chk("sat_cnt_max", if1.stall_cnt, 15);
      if (j == 20) chk("sat_cnt_hold", if1.stall_cnt, 15);
    end
    cyc(); idle(); #1;
    chk("sat_cnt_final", if1.stall_cnt, 15);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
